kb_ps2: RTL and testbench

PS/2 keyboard receiver with a byte FIFO. It sits directly downstream of the `io` address decoder and consumes its `n_kb_oe` and `kb_cp` strobes for the keyboard slot at 0xffx0/0xffx1. It deserialises scan codes from the PS/2 lines, queues them, and presents the data and status bytes to the CPU bus.

---
 rtl/kb_pkg.sv | 22 ++
 rtl/kb_ps2_if.sv | 10 +
 rtl/kb_fifo.sv | 56 +++++
 rtl/kb_ps2.sv | 163 ++++++++++++++++
 tb/tb_kb_ps2.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/kb_pkg.sv
// Shared constants for the PS/2 keyboard receiver: status/command bit positions,
// receiver states and frame length.
package kb_pkg;

    localparam int ST_VALID = 7;
    localparam int ST_OVF   = 6;
    localparam int ST_ERR   = 5;
    localparam int ST_FULL  = 4;

    localparam int CMD_CLR   = 0;
    localparam int CMD_FLUSH = 1;

    localparam int FRAME_LEN = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

endpackage

// File: rtl/kb_ps2_if.sv
// CPU-side strobes, address and write data coming from the io decoder.
interface kb_ps2_if;
    logic       a0;
    logic       n_kb_oe;
    logic       kb_cp;
    logic [7:0] d_in;

    modport master (output a0, n_kb_oe, kb_cp, d_in);
    modport slave  (input  a0, n_kb_oe, kb_cp, d_in);
endinterface

// File: rtl/kb_fifo.sv
// Byte FIFO with a look-ahead head output; flush has priority over push and pop.
module kb_fifo #(
    parameter int LOG_DEPTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic [LOG_DEPTH:0] count,
    output logic               full
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] DEPTH_C = (LOG_DEPTH+1)'(DEPTH);

    logic [7:0]           r_mem [DEPTH];
    logic [LOG_DEPTH-1:0] r_rd_ptr;
    logic [LOG_DEPTH-1:0] r_wr_ptr;
    logic [LOG_DEPTH:0]   r_count;
    logic                 w_pop_ok;
    logic                 w_push_ok;

    assign full      = (r_count == DEPTH_C);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    // A pop frees the slot the simultaneous push needs, so full does not block it then.
    assign w_pop_ok  = pop && (r_count != '0) && !flush;
    assign w_push_ok = push && (!full || w_pop_ok) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/kb_ps2.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes scan codes into
// a FIFO and exposes data/status registers to the CPU bus.
module kb_ps2
    import kb_pkg::*;
#(
    parameter int LOG_DEPTH = 3,
    parameter int TIMEOUT   = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    kb_ps2_if.slave    bus,
    output wire  [7:0] d
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic r_ps2c_s1, r_ps2c_s2, r_ps2c_prev;
    logic r_ps2d_s1, r_ps2d_s2;
    logic w_fall;

    rx_state_t        r_state, w_state_next;
    logic [7:0]       r_shift, w_shift_next;
    logic [2:0]       r_bit, w_bit_next;
    logic             r_par, w_par_next;
    logic [TMO_W-1:0] r_tmo, w_tmo_next;
    logic             r_push, w_push_next;
    logic             r_err_evt, w_err_next;

    logic       r_cp_prev, r_a0;
    logic [1:0] r_cmd;
    logic       r_ovf, r_err;
    logic       w_wr, w_pop, w_clr, w_flush, w_ovf_set;

    logic [7:0]         w_head;
    logic [LOG_DEPTH:0] w_count;
    logic               w_full;
    logic [7:0]         w_status;
    logic [7:0]         w_rd;

    // Everything idles high so a reset never fakes a PS/2 fall or a write strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ps2c_s1   <= 1'b1;
            r_ps2c_s2   <= 1'b1;
            r_ps2c_prev <= 1'b1;
            r_ps2d_s1   <= 1'b1;
            r_ps2d_s2   <= 1'b1;
        end else begin
            r_ps2c_s1   <= ps2_clk;
            r_ps2c_s2   <= r_ps2c_s1;
            r_ps2c_prev <= r_ps2c_s2;
            r_ps2d_s1   <= ps2_data;
            r_ps2d_s2   <= r_ps2d_s1;
        end
    end

    assign w_fall = r_ps2c_prev && !r_ps2c_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit     <= '0;
            r_par     <= 1'b0;
            r_tmo     <= '0;
            r_push    <= 1'b0;
            r_err_evt <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit     <= w_bit_next;
            r_par     <= w_par_next;
            r_tmo     <= w_tmo_next;
            r_push    <= w_push_next;
            r_err_evt <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        w_par_next   = r_par;
        w_tmo_next   = '0;
        w_push_next  = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            IDLE: if (w_fall && !r_ps2d_s2) begin
                w_state_next = DATA;
                w_bit_next   = '0;
            end
            DATA: if (w_fall) begin
                w_shift_next = {r_ps2d_s2, r_shift[7:1]};
                w_bit_next   = r_bit + 3'd1;
                if (r_bit == 3'd7) w_state_next = PARITY;
            end
            PARITY: if (w_fall) begin
                w_par_next   = r_ps2d_s2;
                w_state_next = STOP;
            end
            STOP: if (w_fall) begin
                w_state_next = IDLE;
                if ((^{r_shift, r_par}) && r_ps2d_s2) w_push_next = 1'b1;
                else                                  w_err_next  = 1'b1;
            end
            default: w_state_next = IDLE;
        endcase
        // Counts clk cycles since the last fall while a frame is open.
        if (r_state != IDLE && !w_fall) begin
            if (r_tmo == TMO_LAST) w_state_next = IDLE;
            else                   w_tmo_next   = r_tmo + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cp_prev <= 1'b1;
            r_a0      <= 1'b0;
            r_cmd     <= '0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_cp_prev <= bus.kb_cp;
            r_a0      <= bus.a0;
            r_cmd     <= bus.d_in[1:0];
            r_ovf     <= (r_ovf && !w_clr) || w_ovf_set;
            r_err     <= (r_err && !w_clr) || r_err_evt;
        end
    end

    assign w_wr      = bus.kb_cp && !r_cp_prev;
    assign w_pop     = w_wr && !r_a0;
    assign w_clr     = w_wr && r_a0 && r_cmd[CMD_CLR];
    assign w_flush   = w_wr && r_a0 && r_cmd[CMD_FLUSH];
    assign w_ovf_set = r_push && w_full && !w_pop && !w_flush;

    kb_fifo #(.LOG_DEPTH(LOG_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (r_shift),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full)
    );

    always_comb begin
        w_status           = '0;
        w_status[ST_VALID] = (w_count != '0);
        w_status[ST_OVF]   = r_ovf;
        w_status[ST_ERR]   = r_err;
        w_status[ST_FULL]  = w_full;
        w_status[3:0]      = 4'(w_count);
    end

    assign w_rd = bus.a0 ? w_status : ((w_count == '0) ? 8'h00 : w_head);
    assign d    = bus.n_kb_oe ? 8'hzz : w_rd;

endmodule

// File: tb/tb_kb_ps2.sv
// Directed bench for kb_ps2: a queue-based model of the keyboard FIFO and flags is
// checked every cycle, with literal checkpoints from hand-worked scenarios.
module tb_kb_ps2;
    import kb_pkg::*;

    localparam int TMO   = 2000;
    localparam int HALF  = 10;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    wire [7:0] d;

    kb_ps2_if bus();

    kb_ps2 #(.LOG_DEPTH(3), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus.slave),
        .d        (d)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int settle = 4;
    bit a0_hold = 1'b0;
    byte unsigned mq[$];
    bit m_ovf = 1'b0;
    bit m_err = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic sel);
        int n;
        n = mq.size();
        if (sel) return {(n != 0), m_ovf, m_err, (n == DEPTH), 4'(n)};
        return (n == 0) ? 8'h00 : mq[0];
    endfunction

    // Model: a frame is accepted when stop=1 and the 9 bits hold an odd number of ones.
    task automatic model_rx(input byte unsigned b, input bit par, input bit stop);
        if (stop && ((($countones(b) + int'(par)) % 2) == 1)) begin
            if (mq.size() < DEPTH) mq.push_back(b);
            else m_ovf = 1'b1;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic model_write(input bit addr, input byte unsigned v);
        if (!addr) begin
            if (mq.size() != 0) void'(mq.pop_front());
        end else begin
            if (v[0]) begin m_ovf = 1'b0; m_err = 1'b0; end
            if (v[1]) mq.delete();
        end
    endtask

    always @(negedge clk) begin
        if (settle > 0) settle--;
        else if (!rst && !bus.n_kb_oe)
            check(bus.a0 ? "model_status" : "model_data", d, exp_rd(bus.a0));
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (!a0_hold) bus.a0 = ~bus.a0;
        end
    endtask

    task automatic rd_expect(input string name, input logic sel, input logic [7:0] exp);
        a0_hold = 1'b1;
        @(posedge clk); #1 bus.a0 = sel;
        @(negedge clk); #1 check(name, d, exp);
        @(posedge clk); #1;
        a0_hold = 1'b0;
    endtask

    task automatic cpu_write(input bit addr, input byte unsigned v);
        a0_hold = 1'b1;
        settle = 4;
        @(posedge clk); #1;
        bus.a0 = addr; bus.d_in = v; bus.kb_cp = 1'b0;
        @(posedge clk); #1 bus.kb_cp = 1'b1;
        @(posedge clk); #1;
        model_write(addr, v);
        a0_hold = 1'b0;
    endtask

    // nfalls < FRAME_LEN sends a truncated frame; pop_at_stop lines a pop up with the push.
    task automatic send_frame(input byte unsigned b, input bit par, input bit stop,
                              input int nfalls, input bit pop_at_stop);
        logic [10:0] fr;
        fr = {stop, par, b, 1'b0};
        for (int i = 0; i < nfalls; i++) begin
            ps2_data = fr[i];
            wait_cyc(HALF);
            if (i == FRAME_LEN - 1) begin
                settle = 10;
                if (pop_at_stop) begin
                    a0_hold = 1'b1; bus.a0 = 1'b0; bus.kb_cp = 1'b0;
                    wait_cyc(2);
                    model_write(1'b0, 8'h00);
                end
                model_rx(b, par, stop);
            end
            ps2_clk = 1'b0;
            if (i == FRAME_LEN - 1 && pop_at_stop) begin
                wait_cyc(3);
                bus.kb_cp = 1'b1;
                wait_cyc(1);
                a0_hold = 1'b0;
                wait_cyc(HALF - 1);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic send_good(input byte unsigned b);
        send_frame(b, ~(^b), 1'b1, FRAME_LEN, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.a0 = 1'b0; bus.n_kb_oe = 1'b0; bus.kb_cp = 1'b1; bus.d_in = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rd_expect("reset_status", 1'b1, 8'h00);
        rd_expect("reset_data", 1'b0, 8'h00);

        // Single good frame, then pop.
        send_frame(8'h1C, 1'b0, 1'b1, FRAME_LEN, 1'b0);
        rd_expect("t1_status", 1'b1, 8'h81);
        rd_expect("t1_data", 1'b0, 8'h1C);
        cpu_write(1'b0, 8'h00);
        rd_expect("t1_pop_status", 1'b1, 8'h00);
        rd_expect("t1_pop_data", 1'b0, 8'h00);

        // Parity error, then clear.
        send_frame(8'h1C, 1'b1, 1'b1, FRAME_LEN, 1'b0);
        rd_expect("t2_err_status", 1'b1, 8'h20);
        cpu_write(1'b1, 8'h01);
        rd_expect("t2_clr_status", 1'b1, 8'h00);

        // Overflow with nine bytes, then drain in order.
        for (int i = 1; i <= 9; i++) send_good(8'(i));
        rd_expect("t3_ovf_status", 1'b1, 8'hD8);
        for (int i = 1; i <= 8; i++) begin
            rd_expect("t3_pop_data", 1'b0, 8'(i));
            cpu_write(1'b0, 8'h00);
        end
        rd_expect("t3_drained_status", 1'b1, 8'h40);
        cpu_write(1'b1, 8'h01);

        // Truncated frame abandoned by timeout, then a clean frame.
        send_frame(8'hA5, 1'b1, 1'b1, 5, 1'b0);
        wait_cyc(TMO + 1);
        send_frame(8'h5A, 1'b1, 1'b1, FRAME_LEN, 1'b0);
        rd_expect("t4_status", 1'b1, 8'h81);
        rd_expect("t4_data", 1'b0, 8'h5A);
        cpu_write(1'b0, 8'h00);

        // Push coinciding with pop while full; then flush.
        for (int i = 0; i < DEPTH; i++) send_good(8'(8'h10 + i));
        rd_expect("t5_full_status", 1'b1, 8'h98);
        send_frame(8'h18, ~(^8'h18), 1'b1, FRAME_LEN, 1'b1);
        rd_expect("t5_coincide_status", 1'b1, 8'h98);
        rd_expect("t5_coincide_head", 1'b0, 8'h11);
        cpu_write(1'b1, 8'h02);
        rd_expect("t5_flush_full_status", 1'b1, 8'h00);
        send_good(8'h21); send_good(8'h22); send_good(8'h23);
        rd_expect("t5_three_status", 1'b1, 8'h83);
        cpu_write(1'b1, 8'h02);
        rd_expect("t5_flush_status", 1'b1, 8'h00);

        // Reset mid-frame with a byte queued.
        send_frame(8'h33, 1'b1, 1'b1, FRAME_LEN, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b1, 7, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; settle = 3;
        mq.delete(); m_ovf = 1'b0; m_err = 1'b0;
        wait_cyc(2);
        rst = 1'b0;
        rd_expect("t6_reset_status", 1'b1, 8'h00);
        rd_expect("t6_reset_data", 1'b0, 8'h00);
        send_frame(8'hF0, 1'b1, 1'b1, FRAME_LEN, 1'b0);
        rd_expect("t6_status", 1'b1, 8'h81);
        rd_expect("t6_data", 1'b0, 8'hF0);

        wait_cyc(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
